// File: rtl/approx_adder_err_monitor.sv
// approx_adder_err_monitor: accumulates error statistics of an approximate adder over a programmed run of samples.
module approx_adder_err_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  input  logic [WIDTH:0]   s_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   max_ed,
  output logic [ACC_W-1:0] sum_ed,
  output logic             sum_sat
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d, accepted_q, accepted_d;
  logic             v1_q, v2_q;
  logic [WIDTH:0]   exact_q, approx_q, ed_q, ed_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d;
  logic [WIDTH:0]   max_ed_q, max_ed_d;
  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
  logic             sum_sat_q, sum_sat_d;
  logic [ACC_W:0]   sum_wide;
  logic             take, hs;
  assign s_ready    = (state_q == RUN) && (accepted_q < target_q);
  assign hs         = s_valid && s_ready;
  assign take       = start && (state_q == IDLE || state_q == DONE);
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = state_q == DONE;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign max_ed     = max_ed_q;
  assign sum_ed     = sum_ed_q;
  assign sum_sat    = sum_sat_q;
  always_comb begin
    accepted_d   = take ? '0 : accepted_q + CNT_W'(hs);
    target_d     = take ? num_samples : target_q;
    state_d      = take ? ((num_samples == '0) ? DONE : RUN) :
                   (state_q == RUN && accepted_d == target_q) ? DRAIN :
                   (state_q == DRAIN && !v1_q && !v2_q) ? DONE : state_q;
    ed_d         = (exact_q >= approx_q) ? exact_q - approx_q : approx_q - exact_q;
    // one spare bit catches the overflow that triggers the clamp
    sum_wide     = {1'b0, sum_ed_q} + (ACC_W+1)'(ed_q);
    sample_cnt_d = take ? '0 : sample_cnt_q + CNT_W'(v2_q);
    err_cnt_d    = take ? '0 : err_cnt_q + CNT_W'(v2_q && ed_q != '0);
    max_ed_d     = take ? '0 : (v2_q && ed_q > max_ed_q) ? ed_q : max_ed_q;
    sum_ed_d     = take ? '0 : !v2_q ? sum_ed_q : sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    sum_sat_d    = take ? 1'b0 : sum_sat_q | (v2_q & sum_wide[ACC_W]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      target_q     <= '0;
      accepted_q   <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      exact_q      <= '0;
      approx_q     <= '0;
      ed_q         <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      max_ed_q     <= '0;
      sum_ed_q     <= '0;
      sum_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      accepted_q   <= accepted_d;
      v1_q         <= hs;
      v2_q         <= v1_q;
      if (hs) begin
        exact_q  <= {1'b0, s_a} + {1'b0, s_b};
        approx_q <= s_approx;
      end
      if (v1_q) ed_q <= ed_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      max_ed_q     <= max_ed_d;
      sum_ed_q     <= sum_ed_d;
      sum_sat_q    <= sum_sat_d;
    end
  end
endmodule

// File: doc/approx_adder_err_monitor.md
# approx_adder_err_monitor

Sequential error-evaluation sink for the 16-bit approximate adders in the error-evaluation flow. It accepts operand pairs together with the approximate adder's 17-bit sum over a valid/ready stream. It recomputes the exact sum internally and accumulates these error statistics over a programmed number of samples:

- sample count
- error count
- maximum error distance
- sum of error distances

## Interface

Parameters:
- WIDTH, 16, operand width; sums are WIDTH+1 bits
- CNT_W, 32, width of sample and error counters
- ACC_W, 48, width of error-distance accumulator

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE and DONE only)
- num_samples  in  CNT_W  samples per run; sampled on the cycle start is accepted
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid && s_ready
- s_a  in  WIDTH  operand A
- s_b  in  WIDTH  operand B
- s_approx  in  WIDTH+1  approximate sum under evaluation
- busy  out  1  high in RUN and DRAIN
- done  out  1  high while in DONE
- sample_cnt  out  CNT_W  samples evaluated
- err_cnt  out  CNT_W  samples with s_approx != s_a + s_b
- max_ed  out  WIDTH+1  largest |exact − approx|
- sum_ed  out  ACC_W  saturating sum of |exact − approx|
- sum_sat  out  1  sticky; sum_ed saturated during the run

## Operation

FSM states and transitions:
- IDLE → RUN on start. On the same edge: clear all statistics and sum_sat, latch num_samples into target, clear the accepted counter.
- IDLE → DONE directly on start if num_samples == 0. Statistics are cleared.
- RUN:
  - s_ready = (accepted < target).
  - Each handshake increments accepted.
  - RUN → DRAIN on the edge where accepted reaches target.
- DRAIN: s_ready = 0. Wait until both pipeline stages are empty, then go to DONE.
- DONE: statistics hold. start → RUN or DONE, with the same clear behaviour as from IDLE.

Pipeline, two stages:
- Stage 1 registers exact = s_a + s_b (WIDTH+1 bits, zero-extended) and s_approx, with a valid bit.
- Stage 2 computes ed = (exact ≥ approx) ? exact − approx : approx − exact, unsigned WIDTH+1 bits, then updates:
  - sample_cnt += 1
  - err_cnt += (ed != 0)
  - max_ed = max(max_ed, ed)
  - sum_ed += ed, clamped at 2^ACC_W − 1; set sum_sat on clamp
- sample_cnt and err_cnt wrap modulo 2^CNT_W. This is unreachable when num_samples < 2^CNT_W.

Other rules:
- start while busy is ignored. It does not clear statistics or retarget the run.
- s_valid outside RUN is ignored. The handshake never completes because s_ready is 0.
- Upstream may hold s_valid with changing data while s_ready = 0. Only handshaken data is evaluated.

## Timing

Reset values (asynchronous, rst_n low):
- FSM = IDLE.
- s_ready, busy, done, sum_sat = 0.
- sample_cnt, err_cnt, max_ed, sum_ed = 0.
- Pipeline valids = 0.

Latencies and throughput:
- Start to s_ready: s_ready rises the cycle after start is accepted.
- Statistics latency: a sample handshaken at edge N is reflected in the outputs after edge N+2.
- Throughput: one sample per cycle, with no bubbles while s_valid is held high.

Run length and completion:
- The last handshake is at edge N. DRAIN lasts through edges N+1 and N+2. done = 1 after edge N+3, with final statistics already stable.
- Back-to-back runs: start in DONE clears the outputs on that edge. s_ready rises one cycle later.

Reset mid-run aborts immediately to the reset state. No partial statistics are retained.

## Test plan

1. Reset with all inputs driven high → all outputs 0, FSM in IDLE, and s_ready stays 0 until a start is accepted.
2. start with num_samples = 4. Stream (a, b, approx):
   - (0x0001, 0x0002, 0x00000)
   - (0x00FF, 0x0001, 0x00100)
   - (0xFFFF, 0xFFFF, 0x1FFF0)
   - (0x1234, 0x0000, 0x01230)

   Required response:
   - sample_cnt = 4, err_cnt = 3, max_ed = 0x00E (14), sum_ed = 3 + 0 + 14 + 4 = 21.
   - done asserts exactly 3 cycles after the 4th handshake.
3. Run of 8 exact samples with s_valid toggling every cycle → s_ready drops after the 8th accept, err_cnt = 0, sum_ed = 0, sample_cnt = 8. Extra s_valid pulses are never accepted.
4. start with num_samples = 0 → done after one cycle, all statistics 0, no handshake occurs. A second start pulse in RUN of a 100-sample run leaves target and statistics unaffected.
5. ACC_W = 18 override, 4 samples each with ed = 0x1FFFF → sum_ed = 0x3FFFF, sum_sat = 1, max_ed = 0x1FFFF, err_cnt = 4.
6. Assert rst_n low during RUN after 5 of 10 samples → all outputs 0 immediately. A new 2-sample run then reports only its own two samples.
